tick_flag_gen: RTL
==================

TICK_FLAG_GEN -- requirements
Module: tick_flag_gen

Interface
REQ-001 Parameter W, 16, price width in bits.
REQ-002 Parameter DELTA_MIN, 1, minimum unsigned price move that counts as a move; legal range 1..2^W-1.
REQ-003 Parameter DEPTH, 4, output FIFO depth in entries; power of two, at least 2.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-006 tick_valid  input  1  upstream price tick present.
REQ-007 tick_price  input  W  unsigned tick price; qualified by tick_valid.
REQ-008 tick_ready  output  1  block accepts the tick this cycle.
REQ-009 flag_valid  output  1  head FIFO entry present.
REQ-010 flag_ready  input  1  downstream consumes the head entry this cycle.
REQ-011 a  output  1  head entry up-move flag; feeds the downstream a/b combiner input a.
REQ-012 b  output  1  head entry down-move flag; feeds the combiner input b.
REQ-013 pair_count  output  16  number of entries popped since reset; wraps modulo 2^16.
REQ-014 drop_seen  output  1  sticky flag; set when a tick is presented while the FIFO is full.

Function
REQ-015 A tick is accepted in a cycle only when tick_valid and tick_ready are both 1.
REQ-016 An entry is popped in a cycle only when flag_valid and flag_ready are both 1.
REQ-017 The FSM has two states, PRIME and RUN; reset enters PRIME.
REQ-018 PRIME: tick_ready is 1; an accepted tick loads prev_price, pushes nothing, and moves the FSM to RUN.
REQ-019 RUN: tick_ready equals not-full; there is no bypass when the FIFO is full, even if a pop occurs in the same cycle.
REQ-020 RUN, accepted tick: compute up = tick_price - prev_price and dn = prev_price - tick_price in W+1 bits, so no wrap.
REQ-021 RUN, accepted tick, flag values: a = (tick_price > prev_price) and up >= DELTA_MIN; b = (tick_price < prev_price) and dn >= DELTA_MIN.
REQ-022 a and b are never both 1; a flat move or a sub-threshold move pushes {a=0, b=0}.
REQ-023 RUN, accepted tick: push the {a,b} pair and load prev_price with tick_price in the same cycle.
REQ-024 Latency: a tick accepted at edge N into an empty FIFO makes flag_valid 1, with a and b valid, immediately after edge N. One-cycle latency; outputs driven directly from registers.
REQ-025 While flag_valid is 0, a and b are 0.
REQ-026 FIFO order: strict first in, first out; read and write pointers wrap modulo DEPTH; occupancy counter spans 0..DEPTH.
REQ-027 FIFO, push and pop in the same cycle when not full and not empty: occupancy is unchanged and both pointers advance.
REQ-028 FIFO, pop when empty: cannot occur, because flag_valid is 0.
REQ-029 FIFO, full: tick_ready is 0 in RUN.
REQ-030 drop_seen sets when the FSM is in RUN, the FIFO is full and tick_valid is 1; it clears only on reset.
REQ-031 pair_count increments by 1 on each pop; 16'hFFFF + 1 = 16'h0000.
REQ-032 tick_ready is a function of registered state only, with no combinational path from flag_ready.

Reset
REQ-033 While rst is 1: FSM = PRIME, FIFO empty, pointers 0, prev_price 0, pair_count 0, drop_seen 0.
REQ-034 Output values while rst is 1 and on the first cycle after: flag_valid 0, a 0, b 0, tick_ready 1.
REQ-035 rst has priority over any simultaneous tick or pop; in-flight entries are discarded, and the next accepted tick primes again.

Verification
REQ-036 Prime then moves: with DELTA_MIN=1, flag_ready=1, send ticks 100, 105, 105, 90 -> three entries {1,0}, {0,0}, {0,1}; pair_count=3; the first tick produces no entry.
REQ-037 Threshold: with DELTA_MIN=5, send ticks 100, 104, 109, 104 -> entries {0,0}, {1,0}, {0,1}.
REQ-038 Width extremes: with W=16, send 16'h0000 then 16'hFFFF then 16'h0000 -> {1,0} then {0,1}, with no wrap misclassification.
REQ-039 Backpressure: with flag_ready=0, send 6 ticks -> tick_ready=0 after 5 accepted ticks (1 prime + 4 entries) and drop_seen=1; then release flag_ready -> 4 entries emerge in order, and tick_ready returns to 1 one cycle after the first pop.
REQ-040 Simultaneous push and pop at occupancy 2 -> occupancy stays 2 and order is preserved; pre-load pair_count to 16'hFFFF via pops, then one more pop -> 16'h0000.
REQ-041 Reset mid-stream: rst=1 for one cycle with 3 entries queued -> flag_valid=0 the next cycle; ticks 50, 40 -> a single entry {0,1}.

Source files
------------

// File: rtl/tick_flag_gen.sv
// Price-tick move classifier: compares each accepted tick with the previous one and
// queues an {up, down} flag pair in a small FIFO with registered head outputs.
module tick_flag_gen #(
  parameter int W         = 16,
  parameter int DELTA_MIN = 1,
  parameter int DEPTH     = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick_valid,
  input  logic [W-1:0] tick_price,
  output logic         tick_ready,
  output logic         flag_valid,
  input  logic         flag_ready,
  output logic         a,
  output logic         b,
  output logic [15:0]  pair_count,
  output logic         drop_seen
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ZERO = AW'(1'b0);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
  localparam logic [AW:0]   CNT_ZERO = (AW+1)'(1'b0);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1'b1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [W:0]    DMIN     = (W+1)'(DELTA_MIN);

  typedef enum logic [0:0] {
    PRIME = 1'b0,
    RUN   = 1'b1
  } state_t;

  // Differences are taken one bit wider than the price so neither direction can wrap.
  function automatic logic [1:0] classify(input logic [W-1:0] cur, input logic [W-1:0] prev);
    logic [W:0] up;
    logic [W:0] dn;
    logic       up_f;
    logic       dn_f;
    up   = {1'b0, cur} - {1'b0, prev};
    dn   = {1'b0, prev} - {1'b0, cur};
    up_f = (cur > prev) && (up >= DMIN);
    dn_f = (cur < prev) && (dn >= DMIN);
    classify = {up_f, dn_f};
  endfunction

  state_t         state_r;
  state_t         state_nx_s;
  logic [W-1:0]   prev_r;
  logic [W-1:0]   prev_nx_s;
  logic [1:0]     mem_r [DEPTH];
  logic [AW-1:0]  wr_ptr_r;
  logic [AW-1:0]  rd_ptr_r;
  logic [AW-1:0]  wr_nx_s;
  logic [AW-1:0]  rd_nx_s;
  logic [AW:0]    cnt_r;
  logic [AW:0]    cnt_nx_s;
  logic           flag_valid_r;
  logic           flag_valid_nx_s;
  logic [1:0]     head_r;
  logic [1:0]     head_nx_s;
  logic           tick_ready_r;
  logic           ready_nx_s;
  logic [15:0]    pair_r;
  logic [15:0]    pair_nx_s;
  logic           drop_r;
  logic           drop_nx_s;
  logic           accept_s;
  logic           pop_s;
  logic           push_s;
  logic [1:0]     push_data_s;

  assign accept_s    = tick_valid & tick_ready_r;
  assign pop_s       = flag_valid_r & flag_ready;
  assign push_data_s = classify(tick_price, prev_r);

  assign tick_ready  = tick_ready_r;
  assign flag_valid  = flag_valid_r;
  assign a           = head_r[1];
  assign b           = head_r[0];
  assign pair_count  = pair_r;
  assign drop_seen   = drop_r;

  // FSM next-state: the first accepted tick only primes the reference price
  always_comb begin
    state_nx_s = state_r;
    push_s     = 1'b0;
    case (state_r)
      PRIME: begin
        if (accept_s) begin
          state_nx_s = RUN;
        end else begin
          state_nx_s = PRIME;
        end
      end
      RUN: begin
        push_s     = accept_s;
        state_nx_s = RUN;
      end
      default: begin
        state_nx_s = PRIME;
      end
    endcase
  end

  // FIFO bookkeeping and next values of the registered outputs
  always_comb begin
    prev_nx_s       = prev_r;
    wr_nx_s         = wr_ptr_r;
    rd_nx_s         = rd_ptr_r;
    cnt_nx_s        = cnt_r;
    pair_nx_s       = pair_r;
    drop_nx_s       = drop_r;
    head_nx_s       = 2'b00;
    flag_valid_nx_s = 1'b0;
    ready_nx_s      = 1'b1;

    if (accept_s) begin
      prev_nx_s = tick_price;
    end else begin
      prev_nx_s = prev_r;
    end

    if (push_s) begin
      wr_nx_s = wr_ptr_r + PTR_ONE;
    end else begin
      wr_nx_s = wr_ptr_r;
    end

    if (pop_s) begin
      rd_nx_s   = rd_ptr_r + PTR_ONE;
      pair_nx_s = pair_r + 16'd1;
    end else begin
      rd_nx_s   = rd_ptr_r;
      pair_nx_s = pair_r;
    end

    case ({push_s, pop_s})
      2'b10:   cnt_nx_s = cnt_r + CNT_ONE;
      2'b01:   cnt_nx_s = cnt_r - CNT_ONE;
      default: cnt_nx_s = cnt_r;
    endcase

    // The entry being written this cycle becomes the head when it lands on the read slot.
    if (cnt_nx_s == CNT_ZERO) begin
      head_nx_s = 2'b00;
    end else if (push_s && (rd_nx_s == wr_ptr_r)) begin
      head_nx_s = push_data_s;
    end else begin
      head_nx_s = mem_r[rd_nx_s];
    end

    flag_valid_nx_s = (cnt_nx_s != CNT_ZERO);
    ready_nx_s      = (state_nx_s == PRIME) || (cnt_nx_s != FULL_CNT);

    if ((state_r == RUN) && (cnt_r == FULL_CNT) && tick_valid) begin
      drop_nx_s = 1'b1;
    end else begin
      drop_nx_s = drop_r;
    end
  end

  // State and output registers with synchronous reset priority
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= PRIME;
      prev_r       <= {W{1'b0}};
      wr_ptr_r     <= PTR_ZERO;
      rd_ptr_r     <= PTR_ZERO;
      cnt_r        <= CNT_ZERO;
      flag_valid_r <= 1'b0;
      head_r       <= 2'b00;
      tick_ready_r <= 1'b1;
      pair_r       <= 16'h0000;
      drop_r       <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      prev_r       <= prev_nx_s;
      wr_ptr_r     <= wr_nx_s;
      rd_ptr_r     <= rd_nx_s;
      cnt_r        <= cnt_nx_s;
      flag_valid_r <= flag_valid_nx_s;
      head_r       <= head_nx_s;
      tick_ready_r <= ready_nx_s;
      pair_r       <= pair_nx_s;
      drop_r       <= drop_nx_s;
    end
  end

  // FIFO storage; stale slots are harmless because pointers reset
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= push_data_s;
    end
  end

endmodule
